// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared types and constants for the neuron engine scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  localparam int c_PTR_W       = 6;
  localparam int c_VEC_LEN_DEF = 64;
  localparam int c_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_LOAD     = 3'd2,
    S_THRESH   = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_DONE     = 3'd5,
    S_RELEASE  = 3'd6
  } state_t;

  // Index of the lowest set bit of a one-hot (or zero) vector.
  function automatic logic [c_PTR_W-1:0] f_onehot_idx(input logic [63:0] oh);
    logic [c_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (oh[i]) idx = c_PTR_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker; first requester at or
//                after rr_ptr wins, returned one-hot.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import neuron_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [c_PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0]   winner
);

  logic w_found;
  int   w_idx;

  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(rr_ptr) + i) % N_REQ;
      if (!w_found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_scheduler
//  Description : Arbitrates N_REQ neuron clients onto one engine and sequences
//                load, threshold, result wait (with watchdog) and release.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int VEC_LEN = c_VEC_LEN_DEF,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = c_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    grant,
  output logic [c_PTR_W-1:0]  load_idx,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic [OUT_W-1:0]    result,
  output logic                busy,
  output logic                eng_chip_sel,
  output logic                eng_wr_en,
  output logic                eng_threshold_ready,
  input  logic                eng_output_ready,
  input  logic [OUT_W-1:0]    eng_result
);

  localparam int                 c_WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(VEC_LEN - 1);
  localparam logic [c_PTR_W-1:0] c_LAST_REQ = c_PTR_W'(N_REQ - 1);

  state_t              r_state;
  logic [c_PTR_W-1:0]  r_rr_ptr;
  logic [c_WD_W-1:0]   r_wdog;
  logic                r_rel;

  logic [N_REQ-1:0]    w_winner;
  logic [c_PTR_W-1:0]  w_win_idx;
  logic [c_PTR_W-1:0]  w_next_ptr;

  rr_arbiter #(
    .N_REQ  (N_REQ)
  ) u_arb (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .winner (w_winner)
  );

  always_comb begin
    w_win_idx  = f_onehot_idx(64'(w_winner));
    w_next_ptr = (w_win_idx == c_LAST_REQ) ? '0 : w_win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= S_IDLE;
      r_rr_ptr            <= '0;
      r_wdog              <= '0;
      r_rel               <= 1'b0;
      grant               <= '0;
      load_idx            <= '0;
      done                <= '0;
      err                 <= 1'b0;
      result              <= '0;
      busy                <= 1'b0;
      eng_chip_sel        <= 1'b0;
      eng_wr_en           <= 1'b0;
      eng_threshold_ready <= 1'b0;
    end else begin
      done                <= '0;
      err                 <= 1'b0;
      eng_threshold_ready <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_ARB;
            busy    <= 1'b1;
          end
        end

        S_ARB: begin
          if (|req) begin
            grant        <= w_winner;
            r_rr_ptr     <= w_next_ptr;
            load_idx     <= '0;
            eng_chip_sel <= 1'b1;
            eng_wr_en    <= 1'b1;
            r_state      <= S_LOAD;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (load_idx == c_LAST_IDX) begin
            load_idx            <= '0;
            eng_wr_en           <= 1'b0;
            eng_threshold_ready <= 1'b1;
            r_state             <= S_THRESH;
          end else begin
            load_idx <= load_idx + 1'b1;
          end
        end

        S_THRESH: begin
          r_wdog  <= '0;
          r_state <= S_WAIT_OUT;
        end

        // Engine ready wins over a watchdog expiry landing in the same cycle.
        S_WAIT_OUT: begin
          if (eng_output_ready) begin
            result       <= eng_result;
            done         <= grant;
            eng_chip_sel <= 1'b0;
            r_state      <= S_DONE;
          end else if (r_wdog == c_WD_LAST) begin
            err          <= 1'b1;
            eng_chip_sel <= 1'b0;
            r_rel        <= 1'b0;
            r_state      <= S_RELEASE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        S_DONE: begin
          r_rel   <= 1'b0;
          r_state <= S_RELEASE;
        end

        S_RELEASE: begin
          if (r_rel) begin
            grant   <= '0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rel <= 1'b1;
          end
        end

        default: begin
          grant        <= '0;
          busy         <= 1'b0;
          load_idx     <= '0;
          eng_chip_sel <= 1'b0;
          eng_wr_en    <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_scheduler
//  Description : Directed self-checking bench for neuron_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_scheduler;

  localparam int N_REQ   = 4;
  localparam int VEC_LEN = 64;
  localparam int OUT_W   = 16;
  localparam int TIMEOUT = 255;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0]       grant;
  logic [5:0]       load_idx;
  logic [3:0]       done;
  logic             err;
  logic [15:0]      result;
  logic             busy;
  logic             eng_chip_sel;
  logic             eng_wr_en;
  logic             eng_threshold_ready;
  logic             eng_output_ready;
  logic [15:0]      eng_result;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_scheduler #(
    .N_REQ   (N_REQ),
    .VEC_LEN (VEC_LEN),
    .OUT_W   (OUT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req                 (req),
    .grant               (grant),
    .load_idx            (load_idx),
    .done                (done),
    .err                 (err),
    .result              (result),
    .busy                (busy),
    .eng_chip_sel        (eng_chip_sel),
    .eng_wr_en           (eng_wr_en),
    .eng_threshold_ready (eng_threshold_ready),
    .eng_output_ready    (eng_output_ready),
    .eng_result          (eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job from IDLE with req already driven; ready_dly < 0 means the
  // engine never answers and the watchdog path is expected.
  task automatic do_job(input logic [3:0] exp_g, input int ready_dly,
                        input logic [15:0] res_val, input int drop_at,
                        input int spur_at, input bit clear_req);
    int bad;
    for (int w = 0; w < 10 && eng_wr_en !== 1'b1; w++) @(negedge clk);
    check("load_start", 32'(eng_wr_en), 32'd1);
    check("grant", 32'(grant), 32'(exp_g));

    bad = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      eng_output_ready = 1'b0;
      if (load_idx !== 6'(i) || eng_wr_en !== 1'b1 || eng_chip_sel !== 1'b1 ||
          eng_threshold_ready !== 1'b0 || grant !== exp_g || busy !== 1'b1 ||
          done !== 4'd0)
        bad++;
      if (i == drop_at) req = req & ~exp_g;
      if (i == spur_at) begin
        eng_output_ready = 1'b1;
        eng_result       = 16'hDEAD;
      end
      @(negedge clk);
    end
    eng_output_ready = 1'b0;
    check("load_seq", 32'(bad), 32'd0);
    check("thresh", 32'({eng_chip_sel, eng_wr_en, eng_threshold_ready, load_idx, grant}),
          32'({3'b101, 6'd0, exp_g}));

    bad = 0;
    if (ready_dly >= 0) begin
      for (int k = 1; k <= ready_dly; k++) begin
        @(negedge clk);
        if (eng_chip_sel !== 1'b1 || eng_threshold_ready !== 1'b0 || eng_wr_en !== 1'b0 ||
            done !== 4'd0 || err !== 1'b0)
          bad++;
        if (k == ready_dly) begin
          eng_output_ready = 1'b1;
          eng_result       = res_val;
        end
      end
      check("wait_out", 32'(bad), 32'd0);
      @(negedge clk);
      eng_output_ready = 1'b0;
      eng_result       = 16'h0;
      check("done", 32'(done), 32'(exp_g));
      check("result", 32'(result), 32'(res_val));
      if (clear_req) req = 4'b0000;
      @(negedge clk);
      check("rel1", 32'({done, err, eng_chip_sel, grant}), 32'({4'd0, 1'b0, 1'b0, exp_g}));
    end else begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge clk);
        if (err !== 1'b0 || done !== 4'd0 || eng_chip_sel !== 1'b1) bad++;
      end
      check("wait_timeout", 32'(bad), 32'd0);
      @(negedge clk);
      check("err_pulse", 32'({err, done, eng_chip_sel, grant}), 32'({1'b1, 4'd0, 1'b0, exp_g}));
      check("result_hold", 32'(result), 32'(res_val));
      if (clear_req) req = 4'b0000;
    end
    @(negedge clk);
    check("rel2", 32'({done, err, eng_chip_sel, grant, busy}),
          32'({4'd0, 1'b0, 1'b0, exp_g, 1'b1}));
    @(negedge clk);
    check("release_end", 32'({grant, busy}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    req              = 4'b0000;
    eng_output_ready = 1'b0;
    eng_result       = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({grant, done, err, busy, eng_chip_sel, eng_wr_en, eng_threshold_ready}), 32'd0);
    check("rst_data", 32'({load_idx, result}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_no_req", 32'({busy, grant}), 32'd0);

    // Fairness with all clients requesting continuously
    req = 4'b1111;
    do_job(4'b0001, 3, 16'h0011, -1, -1, 1'b0);
    do_job(4'b0010, 3, 16'h0022, -1, -1, 1'b0);
    do_job(4'b0100, 3, 16'h0044, -1, -1, 1'b0);
    do_job(4'b1000, 3, 16'h0088, -1, -1, 1'b0);
    do_job(4'b0001, 3, 16'h0101, -1, -1, 1'b1);

    // Single job, engine answers 20 cycles after THRESH
    req = 4'b0010;
    do_job(4'b0010, 20, 16'h00A5, -1, -1, 1'b1);

    // Owner drops req at load_idx 10
    req = 4'b0100;
    do_job(4'b0100, 5, 16'h1234, 10, -1, 1'b1);
    check("drop_idle", 32'(req), 32'd0);

    // Watchdog timeout, previous result must survive
    req = 4'b0001;
    do_job(4'b0001, -1, 16'h1234, -1, -1, 1'b1);

    // Spurious ready during LOAD
    req = 4'b1000;
    do_job(4'b1000, 2, 16'hBEEF, -1, 5, 1'b1);

    // Reset mid-LOAD
    req = 4'b0100;
    for (int w = 0; w < 10 && eng_wr_en !== 1'b1; w++) @(negedge clk);
    for (int w = 0; w < 70 && load_idx !== 6'd30; w++) @(negedge clk);
    check("at_idx30", 32'(load_idx), 32'd30);
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({grant, done, err, busy, eng_chip_sel, eng_wr_en, eng_threshold_ready}), 32'd0);
    check("midrst_data", 32'({load_idx, result}), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check("midrst_hold", 32'({done, busy, grant}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b1000;
    do_job(4'b1000, 4, 16'h0F0F, -1, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
